// File: rtl/downsample_engine_if.sv
// rtl/downsample_engine_if.sv - data-memory read/write bus between the downsampler and memory
`timescale 1ns/1ps
interface downsample_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/downsample_engine.sv
// rtl/downsample_engine.sv - FxF window average/decimate image downsampler on the data-memory bus
`timescale 1ns/1ps
module downsample_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19,
    parameter int DIM_W  = 10
) (
    input  logic                clk,
    input  logic                RST_N,
    input  logic                start,
    input  logic                factor4,
    input  logic                decimate,
    input  logic [DIM_W-1:0]    img_w,
    input  logic [DIM_W-1:0]    img_h,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    downsample_engine_if.master mem,
    output logic                busy,
    output logic                done
);
    localparam int ACC_W = DATA_W + 4;
    localparam int PW    = DIM_W + ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t            state_q;
    logic              factor4_q, decimate_q;
    logic [DIM_W-1:0]  img_w_q, img_h_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [DIM_W-1:0]  ox_q, oy_q;
    logic [1:0]        kx_q, ky_q;
    logic [ACC_W-1:0]  acc_q;
    logic              rd_req_q, wr_en_q, busy_q, done_q;

    logic [1:0]        fsh, kmax;
    logic [DIM_W-1:0]  ow, oh, row, col;
    logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
    logic [ACC_W-1:0]  rnd_sum;
    logic [DATA_W-1:0] wr_data_c;
    logic              win_done, last_col, last_row;

    assign fsh  = factor4_q ? 2'd2 : 2'd1;
    assign kmax = factor4_q ? 2'd3 : 2'd1;
    assign ow   = img_w_q >> fsh;
    assign oh   = img_h_q >> fsh;
    assign row  = (oy_q << fsh) + DIM_W'(ky_q);
    assign col  = (ox_q << fsh) + DIM_W'(kx_q);

    // Products are formed wide and truncated so address arithmetic wraps modulo 2^ADDR_W
    assign rd_addr_c = src_q + ADDR_W'(PW'(row) * PW'(img_w_q)) + ADDR_W'(col);
    assign wr_addr_c = dst_q + ADDR_W'(PW'(oy_q) * PW'(ow)) + ADDR_W'(ox_q);

    assign rnd_sum   = acc_q + (factor4_q ? ACC_W'(8) : ACC_W'(2));
    assign wr_data_c = decimate_q ? acc_q[DATA_W-1:0]
                                  : DATA_W'(rnd_sum >> (factor4_q ? 3'd4 : 3'd2));

    assign win_done = decimate_q || (kx_q == kmax && ky_q == kmax);
    assign last_col = (ox_q == ow - 1'b1);
    assign last_row = (oy_q == oh - 1'b1);

    assign mem.rd_req  = rd_req_q;
    assign mem.rd_addr = rd_req_q ? rd_addr_c : '0;
    assign mem.wr_en   = wr_en_q;
    assign mem.wr_addr = wr_en_q ? wr_addr_c : '0;
    assign mem.wr_data = wr_en_q ? wr_data_c : '0;
    assign busy        = busy_q;
    assign done        = done_q;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            factor4_q  <= 1'b0;
            decimate_q <= 1'b0;
            img_w_q    <= '0;
            img_h_q    <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            acc_q      <= '0;
            rd_req_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    factor4_q  <= factor4;
                    decimate_q <= decimate;
                    img_w_q    <= img_w;
                    img_h_q    <= img_h;
                    src_q      <= src_base;
                    dst_q      <= dst_base;
                    busy_q     <= 1'b1;
                    state_q    <= S_CHECK;
                end
                S_CHECK: begin
                    ox_q  <= '0;
                    oy_q  <= '0;
                    kx_q  <= '0;
                    ky_q  <= '0;
                    acc_q <= '0;
                    if (ow == '0 || oh == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        rd_req_q <= 1'b1;
                        state_q  <= S_RD;
                    end
                end
                S_RD: begin
                    rd_req_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: if (mem.rd_valid) begin
                    acc_q <= acc_q + ACC_W'(mem.rd_data);
                    if (win_done) begin
                        wr_en_q <= 1'b1;
                        state_q <= S_WR;
                    end else begin
                        if (kx_q == kmax) begin
                            kx_q <= '0;
                            ky_q <= ky_q + 2'd1;
                        end else begin
                            kx_q <= kx_q + 2'd1;
                        end
                        rd_req_q <= 1'b1;
                        state_q  <= S_RD;
                    end
                end
                S_WR: if (mem.wr_ready) begin
                    wr_en_q <= 1'b0;
                    acc_q   <= '0;
                    kx_q    <= '0;
                    ky_q    <= '0;
                    if (last_col) begin
                        ox_q <= '0;
                        oy_q <= oy_q + 1'b1;
                    end else begin
                        ox_q <= ox_q + 1'b1;
                    end
                    if (last_col && last_row) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        rd_req_q <= 1'b1;
                        state_q  <= S_RD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_downsample_engine.sv
// tb/tb_downsample_engine.sv - scoreboard bench for downsample_engine with a latency-programmable memory model
`timescale 1ns/1ps
module tb_downsample_engine;
    logic        clk;
    logic        RST_N;
    logic        start, factor4, decimate;
    logic [9:0]  img_w, img_h;
    logic [18:0] src_base, dst_base;
    logic        busy, done;

    downsample_engine_if #(.DATA_W(8), .ADDR_W(19)) mem_if ();

    downsample_engine #(.DATA_W(8), .ADDR_W(19), .DIM_W(10)) dut (
        .clk(clk), .RST_N(RST_N), .start(start), .factor4(factor4), .decimate(decimate),
        .img_w(img_w), .img_h(img_h), .src_base(src_base), .dst_base(dst_base),
        .mem(mem_if.master), .busy(busy), .done(done)
    );

    logic [7:0] mem [0:1023];
    int exp_rd_q[$];
    int exp_wa[$];
    int exp_wd[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, latency = 1, stall_left = 0;
    int n_vec = 0, n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " rd_req"}, int'(mem_if.rd_req), 0);
        check({tag, " rd_addr"}, int'(mem_if.rd_addr), 0);
        check({tag, " wr_en"}, int'(mem_if.wr_en), 0);
        check({tag, " wr_addr"}, int'(mem_if.wr_addr), 0);
        check({tag, " wr_data"}, int'(mem_if.wr_data), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
    endtask

    // Memory responder and scoreboard consumer: everything is sampled and driven at negedge
    initial begin : responder
        int pend;
        logic [9:0]  raddr;
        logic [18:0] hold_a;
        logic [7:0]  hold_d;
        bit holding;
        pend = 0; holding = 0; raddr = '0; hold_a = '0; hold_d = '0;
        mem_if.rd_valid = 1'b0;
        mem_if.rd_data  = '0;
        mem_if.wr_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_if.rd_valid = 1'b0;
            mem_if.wr_ready = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy during done", int'(busy), 0);
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_if.rd_valid = 1'b1;
                    mem_if.rd_data  = mem[raddr];
                end
            end
            if (mem_if.rd_req) begin
                rd_cnt++;
                check("single outstanding read", pend, 0);
                check("busy during read", int'(busy), 1);
                check("read expected", int'(exp_rd_q.size() > 0), 1);
                if (exp_rd_q.size() > 0) check("rd_addr", int'(mem_if.rd_addr), exp_rd_q.pop_front());
                raddr = mem_if.rd_addr[9:0];
                pend  = latency;
            end
            if (mem_if.wr_en) begin
                if (stall_left > 0) begin
                    if (!holding) begin
                        hold_a  = mem_if.wr_addr;
                        hold_d  = mem_if.wr_data;
                        holding = 1;
                    end else begin
                        check("stalled wr_addr", int'(mem_if.wr_addr), int'(hold_a));
                        check("stalled wr_data", int'(mem_if.wr_data), int'(hold_d));
                    end
                    check("no rd_req while stalled", int'(mem_if.rd_req), 0);
                    stall_left--;
                end else begin
                    if (holding) check("released wr_addr", int'(mem_if.wr_addr), int'(hold_a));
                    holding = 0;
                    mem_if.wr_ready = 1'b1;
                    wr_cnt++;
                    check("write expected", int'(exp_wa.size() > 0), 1);
                    if (exp_wa.size() > 0) begin
                        check("wr_addr", int'(mem_if.wr_addr), exp_wa.pop_front());
                        check("wr_data", int'(mem_if.wr_data), exp_wd.pop_front());
                    end
                end
            end
        end
    end

    task automatic model_push(input bit f4, input bit dec, input int w, input int h,
                              input int src, input int dst, input bit push_wr);
        int f, ow, oh, k, a, acc;
        f  = f4 ? 4 : 2;
        ow = w / f;
        oh = h / f;
        k  = dec ? 1 : f;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                acc = 0;
                for (int ky = 0; ky < k; ky++) begin
                    for (int kx = 0; kx < k; kx++) begin
                        a = src + (oy * f + ky) * w + ox * f + kx;
                        exp_rd_q.push_back(a);
                        acc += int'(mem[a]);
                    end
                end
                if (push_wr) begin
                    exp_wa.push_back(dst + oy * ow + ox);
                    exp_wd.push_back(dec ? acc : (acc + f * f / 2) / (f * f));
                end
            end
        end
    endtask

    task automatic push_wr4(input int dst, input int d0, input int d1, input int d2, input int d3);
        exp_wa.push_back(dst);     exp_wd.push_back(d0);
        exp_wa.push_back(dst + 1); exp_wd.push_back(d1);
        exp_wa.push_back(dst + 2); exp_wd.push_back(d2);
        exp_wa.push_back(dst + 3); exp_wd.push_back(d3);
    endtask

    task automatic set_cfg(input bit f4, input bit dec, input int w, input int h,
                           input int src, input int dst, input int lat, input int stall);
        factor4 = f4; decimate = dec;
        img_w = 10'(w); img_h = 10'(h);
        src_base = 19'(src); dst_base = 19'(dst);
        latency = lat; stall_left = stall;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input string tag, input bit f4, input bit dec, input int w, input int h,
                           input int src, input int dst, input int lat, input int stall);
        int f, n, npix, d0, r0, w0, b;
        f    = f4 ? 4 : 2;
        n    = dec ? 1 : f * f;
        npix = (w / f) * (h / f);
        set_cfg(f4, dec, w, h, src, dst, lat, stall);
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt; b = 0;
        pulse_start();
        while (done_cnt == d0 && b < 5000) begin
            @(negedge clk); #1;
            b++;
        end
        repeat (3) begin @(negedge clk); #1; end
        check({tag, " done pulses"}, done_cnt - d0, 1);
        check({tag, " cycles start->done"}, done_cyc - start_cyc, 2 + npix * (n * (lat + 1) + 1) + stall);
        check({tag, " reads"}, rd_cnt - r0, npix * n);
        check({tag, " writes"}, wr_cnt - w0, npix);
        check({tag, " reads left"}, exp_rd_q.size(), 0);
        check({tag, " writes left"}, exp_wa.size(), 0);
    endtask

    task automatic load_img4(input int base);
        int px[16] = '{1, 2, 5, 5, 2, 2, 5, 5, 0, 0, 255, 255, 0, 1, 255, 255};
        for (int i = 0; i < 16; i++) mem[base + i] = 8'(px[i]);
    endtask

    initial begin : watchdog
        #900us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int r0, w0, b;
        RST_N = 1'b0; start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        load_img4(16);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++) mem[200 + r * 8 + c] = 8'd255;

        repeat (3) @(negedge clk);
        #1 check_idle("reset");
        RST_N = 1'b1;
        @(negedge clk); #1 check_idle("after reset");

        model_push(0, 0, 4, 4, 16, 600, 0);
        push_wr4(600, 2, 5, 0, 255);
        run_job("s1 avg F2", 0, 0, 4, 4, 16, 600, 1, 0);

        exp_rd_q.push_back(16); exp_rd_q.push_back(18);
        exp_rd_q.push_back(24); exp_rd_q.push_back(26);
        push_wr4(610, 1, 5, 0, 255);
        run_job("s2 decimate F2", 0, 1, 4, 4, 16, 610, 2, 0);

        model_push(0, 0, 5, 3, 100, 620, 1);
        run_job("s3 remainder", 0, 0, 5, 3, 100, 620, 1, 0);

        set_cfg(1, 0, 3, 8, 100, 630, 1, 0);
        r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        check("s4 busy in check", int'(busy), 1);
        check("s4 done early", int'(done), 0);
        @(negedge clk); #1;
        check("s4 done", int'(done), 1);
        check("s4 busy at done", int'(busy), 0);
        @(negedge clk); #1;
        check("s4 done width", int'(done), 0);
        check("s4 reads", rd_cnt - r0, 0);
        check("s4 writes", wr_cnt - w0, 0);

        model_push(0, 0, 4, 4, 16, 640, 0);
        push_wr4(640, 2, 5, 0, 255);
        run_job("s5 write stall", 0, 0, 4, 4, 16, 640, 2, 5);

        model_push(1, 0, 8, 5, 200, 650, 1);
        run_job("F4 avg", 1, 0, 8, 5, 200, 650, 3, 0);
        model_push(1, 1, 9, 8, 300, 660, 1);
        run_job("F4 decimate", 1, 1, 9, 8, 300, 660, 1, 0);

        model_push(0, 0, 4, 4, 16, 700, 1);
        set_cfg(0, 0, 4, 4, 16, 700, 4, 0);
        r0 = rd_cnt; w0 = wr_cnt; b = 0;
        pulse_start();
        while (rd_cnt == r0 && b < 100) begin
            @(negedge clk); #1;
            b++;
        end
        check("s6 first read", rd_cnt - r0, 1);
        @(negedge clk); #1;
        RST_N = 1'b0;
        #1 check_idle("s6 in reset");
        @(negedge clk); #1;
        RST_N = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            check("s6 rd_req after abort", int'(mem_if.rd_req), 0);
            check("s6 busy after abort", int'(busy), 0);
        end
        check("s6 writes after abort", wr_cnt - w0, 0);
        exp_rd_q.delete(); exp_wa.delete(); exp_wd.delete();

        model_push(0, 0, 4, 4, 16, 600, 0);
        push_wr4(600, 2, 5, 0, 255);
        run_job("s6 rerun", 0, 0, 4, 4, 16, 600, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
